// File: rtl/secuenciador_acceso_rtc.sv
// secuenciador_acceso_rtc: sequences RTC read sweeps and configuration write sweeps over a req/ack bus handshake
module secuenciador_acceso_rtc #(
   parameter logic [7:0]  DIR_BASE_HORA  = 8'h21,
   parameter logic [7:0]  DIR_BASE_FECHA = 8'h24,
   parameter logic [7:0]  DIR_BASE_TIMER = 8'h41,
   parameter int unsigned TIMEOUT        = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_refresco,
   input  logic       pulso_escribir,
   input  logic [2:0] funcion_conf,
   input  logic       flag_mostrar_count,
   input  logic       ack_bus,
   output logic       req_bus,
   output logic       rw_bus,
   output logic [7:0] dir_bus,
   output logic [3:0] indice_reg,
   output logic       ocupado,
   output logic       fin_barrido,
   output logic       error_timeout
);
   typedef enum logic [1:0] {REPOSO, PEDIR, ESPERA_ACK, PAUSA} estado_t;
   estado_t    r_estado, w_estado_sig;
   logic [3:0] r_idx, w_idx_sig, r_idx_fin, w_idx_fin_sig;
   logic       r_rw, w_rw_sig;
   logic [7:0] r_cnt, w_cnt_sig;
   logic       r_lec_pend, w_lec_pend_sig, r_esc_pend, w_esc_pend_sig;
   logic [2:0] r_grupo, w_grupo_sig;
   logic       w_esc_nueva;
   logic [3:0] w_idx_ini_esc, w_idx_fin_esc;
   logic [7:0] w_dir;

   // only one-hot group codes queue a write; anything else drops the strobe
   assign w_esc_nueva   = pulso_escribir && (funcion_conf inside {3'b001, 3'b010, 3'b100});
   assign w_grupo_sig   = w_esc_nueva ? funcion_conf : r_grupo;
   assign w_idx_ini_esc = w_grupo_sig == 3'b001 ? 4'd0 : w_grupo_sig == 3'b010 ? 4'd3 : 4'd7;
   assign w_idx_fin_esc = w_grupo_sig == 3'b001 ? 4'd2 : w_grupo_sig == 3'b010 ? 4'd6 : 4'd9;
   assign w_dir = r_idx < 4'd3 ? DIR_BASE_HORA + {4'b0000, r_idx} :
                  r_idx < 4'd7 ? DIR_BASE_FECHA + {4'b0000, r_idx - 4'd3} :
                                 DIR_BASE_TIMER + {4'b0000, r_idx - 4'd7};
   // req is decoded from state so an async reset removes it at once
   assign req_bus    = r_estado == PEDIR || r_estado == ESPERA_ACK;
   assign ocupado    = r_estado != REPOSO;
   assign rw_bus     = r_rw;
   assign indice_reg = r_idx;
   assign dir_bus    = req_bus ? w_dir : 8'h00;

   // next-state, queue bookkeeping and end-of-sweep pulses
   always_comb begin
      w_estado_sig   = r_estado;
      w_idx_sig      = r_idx;
      w_idx_fin_sig  = r_idx_fin;
      w_rw_sig       = r_rw;
      w_cnt_sig      = r_cnt;
      w_lec_pend_sig = r_lec_pend | tick_refresco;
      w_esc_pend_sig = r_esc_pend | w_esc_nueva;
      fin_barrido    = 1'b0;
      error_timeout  = 1'b0;
      case (r_estado)
         REPOSO: begin
            if (w_esc_pend_sig) begin
               w_estado_sig   = PEDIR;
               w_idx_sig      = w_idx_ini_esc;
               w_idx_fin_sig  = w_idx_fin_esc;
               w_rw_sig       = 1'b0;
               w_esc_pend_sig = 1'b0;
            end else if (w_lec_pend_sig) begin
               w_estado_sig   = PEDIR;
               w_idx_sig      = 4'd0;
               w_idx_fin_sig  = flag_mostrar_count ? 4'd9 : 4'd6;
               w_rw_sig       = 1'b1;
               w_lec_pend_sig = 1'b0;
            end
         end
         PEDIR: begin
            w_cnt_sig    = 8'd0;
            w_estado_sig = ESPERA_ACK;
         end
         ESPERA_ACK: begin
            if (ack_bus) begin
               w_estado_sig = PAUSA;
            end else if (r_cnt == 8'(TIMEOUT - 1)) begin
               w_estado_sig  = REPOSO;
               error_timeout = 1'b1;
            end else begin
               w_cnt_sig = r_cnt + 8'd1;
            end
         end
         PAUSA: begin
            if (r_idx == r_idx_fin) begin
               w_estado_sig = REPOSO;
               fin_barrido  = 1'b1;
            end else begin
               w_idx_sig    = r_idx + 4'd1;
               w_estado_sig = PEDIR;
            end
         end
         default: w_estado_sig = REPOSO;
      endcase
   end

   // state and sweep context registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado   <= REPOSO;
         r_idx      <= 4'd0;
         r_idx_fin  <= 4'd0;
         r_rw       <= 1'b0;
         r_cnt      <= 8'd0;
         r_lec_pend <= 1'b0;
         r_esc_pend <= 1'b0;
         r_grupo    <= 3'b000;
      end else begin
         r_estado   <= w_estado_sig;
         r_idx      <= w_idx_sig;
         r_idx_fin  <= w_idx_fin_sig;
         r_rw       <= w_rw_sig;
         r_cnt      <= w_cnt_sig;
         r_lec_pend <= w_lec_pend_sig;
         r_esc_pend <= w_esc_pend_sig;
         r_grupo    <= w_grupo_sig;
      end
   end
endmodule

// File: tb/tb_secuenciador_acceso_rtc.sv
// tb_secuenciador_acceso_rtc: directed self-checking bench for the RTC access sequencer
module tb_secuenciador_acceso_rtc;
   logic       clk = 1'b0, reset = 1'b0, tick_refresco = 1'b0, pulso_escribir = 1'b0;
   logic       flag_mostrar_count = 1'b0, ack_bus = 1'b0;
   logic [2:0] funcion_conf = 3'b000;
   logic       req_bus, rw_bus, ocupado, fin_barrido, error_timeout;
   logic [7:0] dir_bus;
   logic [3:0] indice_reg;
   int         checks = 0, errors = 0;
   int         n_req, n_err, n_fin;
   logic [7:0] tabla [10] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h41, 8'h42, 8'h43};

   secuenciador_acceso_rtc dut (
      .clk(clk), .reset(reset), .tick_refresco(tick_refresco), .pulso_escribir(pulso_escribir),
      .funcion_conf(funcion_conf), .flag_mostrar_count(flag_mostrar_count), .ack_bus(ack_bus),
      .req_bus(req_bus), .rw_bus(rw_bus), .dir_bus(dir_bus), .indice_reg(indice_reg),
      .ocupado(ocupado), .fin_barrido(fin_barrido), .error_timeout(error_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic txn(input int i, input logic rw, input logic last, input logic first);
      int w = 0;
      if (first) while (!req_bus && w < 20) begin @(negedge clk); w++; end
      chk("req_alto", 32'(req_bus), 1);
      chk("dir", 32'(dir_bus), 32'(tabla[i]));
      chk("indice", 32'(indice_reg), 32'(i));
      chk("rw", 32'(rw_bus), 32'(rw));
      repeat (3) begin
         @(negedge clk);
         chk("req_sostenido", 32'(req_bus), 1);
         chk("dir_estable", 32'(dir_bus), 32'(tabla[i]));
         chk("rw_estable", 32'(rw_bus), 32'(rw));
      end
      ack_bus = 1'b1;
      @(negedge clk);
      ack_bus = 1'b0;
      chk("req_pausa", 32'(req_bus), 0);
      chk("fin_barrido", 32'(fin_barrido), 32'(last));
      chk("error_timeout_pausa", 32'(error_timeout), 0);
      @(negedge clk);
   endtask

   task automatic sweep(input int i0, input int i1, input logic rw);
      for (int i = i0; i <= i1; i++) txn(i, rw, i == i1, i == i0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         chk("req_reposo", 32'(req_bus), 0);
         chk("ocupado_reposo", 32'(ocupado), 0);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_req", 32'(req_bus), 0);
      chk("rst_ocupado", 32'(ocupado), 0);
      chk("rst_dir", 32'(dir_bus), 0);
      chk("rst_indice", 32'(indice_reg), 0);
      chk("rst_rw", 32'(rw_bus), 0);
      chk("rst_fin", 32'(fin_barrido), 0);
      chk("rst_err", 32'(error_timeout), 0);
      reset = 1'b1;
      idle(2);
      tick_refresco = 1'b1;
      @(negedge clk);
      tick_refresco = 1'b0;
      sweep(0, 6, 1'b1);
      chk("lectura7_ocupado", 32'(ocupado), 0);
      tick_refresco = 1'b1;
      flag_mostrar_count = 1'b1;
      @(negedge clk);
      tick_refresco = 1'b0;
      flag_mostrar_count = 1'b0;
      sweep(0, 9, 1'b1);
      chk("lectura10_ocupado", 32'(ocupado), 0);
      funcion_conf = 3'b010;
      pulso_escribir = 1'b1;
      @(negedge clk);
      pulso_escribir = 1'b0;
      funcion_conf = 3'b000;
      sweep(3, 6, 1'b0);
      chk("fecha_ocupado", 32'(ocupado), 0);
      pulso_escribir = 1'b1;
      @(negedge clk);
      funcion_conf = 3'b011;
      @(negedge clk);
      pulso_escribir = 1'b0;
      ack_bus = 1'b1;
      @(negedge clk);
      ack_bus = 1'b0;
      idle(5);
      tick_refresco = 1'b1;
      pulso_escribir = 1'b1;
      funcion_conf = 3'b100;
      @(negedge clk);
      tick_refresco = 1'b0;
      pulso_escribir = 1'b0;
      funcion_conf = 3'b000;
      sweep(7, 9, 1'b0);
      sweep(0, 6, 1'b1);
      chk("mixto_ocupado", 32'(ocupado), 0);
      tick_refresco = 1'b1;
      @(negedge clk);
      tick_refresco = 1'b0;
      @(negedge clk);
      tick_refresco = 1'b1;
      @(negedge clk);
      tick_refresco = 1'b0;
      @(negedge clk);
      tick_refresco = 1'b1;
      @(negedge clk);
      tick_refresco = 1'b0;
      sweep(0, 6, 1'b1);
      sweep(0, 6, 1'b1);
      idle(10);
      tick_refresco = 1'b1;
      @(negedge clk);
      tick_refresco = 1'b0;
      n_req = 0;
      n_err = 0;
      n_fin = 0;
      for (int k = 0; k < 400; k++) begin
         if (req_bus) n_req++;
         if (error_timeout) n_err++;
         if (fin_barrido) n_fin++;
         if (!ocupado) break;
         @(negedge clk);
      end
      chk("timeout_ciclos_req", 32'(n_req), 256);
      chk("timeout_pulsos_err", 32'(n_err), 1);
      chk("timeout_sin_fin", 32'(n_fin), 0);
      chk("timeout_ocupado", 32'(ocupado), 0);
      idle(3);
      tick_refresco = 1'b1;
      @(negedge clk);
      tick_refresco = 1'b0;
      repeat (3) @(negedge clk);
      tick_refresco = 1'b1;
      pulso_escribir = 1'b1;
      funcion_conf = 3'b001;
      @(negedge clk);
      tick_refresco = 1'b0;
      pulso_escribir = 1'b0;
      funcion_conf = 3'b000;
      chk("pre_reset_req", 32'(req_bus), 1);
      #2 reset = 1'b0;
      #1;
      chk("reset_async_req", 32'(req_bus), 0);
      chk("reset_async_ocupado", 32'(ocupado), 0);
      @(negedge clk);
      reset = 1'b1;
      idle(10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
